// File: rtl/ddc_frame_packer.sv
// ddc_frame_packer
// Rounds the four 34-bit DDC sample streams (L/R, I/Q) to 16 bits and packs
// each sample set into one 64-bit word {L_i, L_q, R_i, R_q}. It then frames the
// words into packets of PKT_WORDS payload words, each preceded by a header word
// {MAGIC, PKT_WORDS[15:0], seq_num}. The result is a valid/ready stream.
//
// Ports
//   rd_clk, rst_n            clock, asynchronous active-low reset
//   din_L_i/L_q/R_i/R_q      signed DATA_WIDTH samples; din_valid qualifies all four
//   pkt_en                   enables accepting samples and starting packets
//   dout, dout_valid         output word and its valid flag
//   dout_ready               sink accepts dout this cycle
//   dout_sop, dout_eop       header word / last payload word markers
//   seq_num                  sequence number of the current or next packet
//   ovf_cnt                  saturating count of sample sets dropped on a full buffer
module ddc_frame_packer #(
  parameter int          DATA_WIDTH = 34,
  parameter int          OUT_WIDTH  = 16,
  parameter int          PKT_WORDS  = 256,
  parameter int          FIFO_AW    = 4,
  parameter logic [15:0] MAGIC      = 16'hDDC5
) (
  input  logic                         rd_clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] din_L_i,
  input  logic signed [DATA_WIDTH-1:0] din_L_q,
  input  logic signed [DATA_WIDTH-1:0] din_R_i,
  input  logic signed [DATA_WIDTH-1:0] din_R_q,
  input  logic                         din_valid,
  input  logic                         pkt_en,
  output logic [63:0]                  dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         dout_sop,
  output logic                         dout_eop,
  output logic [31:0]                  seq_num,
  output logic [15:0]                  ovf_cnt
);

  localparam int S     = DATA_WIDTH - OUT_WIDTH;
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;

  localparam logic [15:0]      PKT_LEN  = 16'(PKT_WORDS);
  localparam logic [15:0]      LAST_IDX = 16'(PKT_WORDS - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  // Round half up by adding half an output LSB, then keep the upper bits.
  // Only non-negative inputs can carry into the sign bit, so saturation is
  // one-sided.
  function automatic logic signed [OUT_WIDTH-1:0] round_sat(
    input logic signed [DATA_WIDTH-1:0] x
  );
    logic signed [DATA_WIDTH:0] half;
    logic signed [DATA_WIDTH:0] r;
    half = $signed({{(DATA_WIDTH - S + 1){1'b0}}, 1'b1, {(S - 1){1'b0}}});
    r    = $signed({x[DATA_WIDTH-1], x}) + half;
    if (!x[DATA_WIDTH-1] && r[DATA_WIDTH-1]) begin
      return {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    end
    return r[DATA_WIDTH-1:S];
  endfunction

  // ---- Stage p0: rounding register ----
  logic [63:0] smp_p0_q;
  logic        vld_p0_q;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) vld_p0_q <= 1'b0;
    else        vld_p0_q <= din_valid;
  end

  always_ff @(posedge rd_clk) begin
    if (din_valid) begin
      smp_p0_q <= {round_sat(din_L_i), round_sat(din_L_q),
                   round_sat(din_R_i), round_sat(din_R_q)};
    end
  end

  // ---- Stage p1: elastic buffer ----
  logic [63:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   cnt_q;
  logic               buf_empty, buf_full, wr_gate, wr_en, drop, rd_en;
  logic [1:0]         state_q, state_d;

  assign buf_empty = (cnt_q == '0);
  assign buf_full  = (cnt_q == FULL_CNT);
  // Once a packet has started, samples keep flowing in regardless of pkt_en.
  assign wr_gate   = (state_q == ST_IDLE) ? pkt_en : 1'b1;
  // A read in the same cycle frees a slot, so a full buffer still accepts.
  assign wr_en     = vld_p0_q && wr_gate && (!buf_full || rd_en);
  assign drop      = vld_p0_q && wr_gate && buf_full && !rd_en;

  always_ff @(posedge rd_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= smp_p0_q;
  end

  // ---- Stage p2: framing FSM and output register ----
  logic [63:0] dout_q, dout_d;
  logic        dvld_q, dvld_d, sop_q, sop_d, eop_q, eop_d, xfer;
  logic [15:0] wcnt_q, wcnt_d, ovf_q;
  logic [31:0] seq_q, seq_d;

  assign xfer = dvld_q && dout_ready;

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    dvld_d  = dvld_q && !dout_ready;
    sop_d   = xfer ? 1'b0 : sop_q;
    eop_d   = xfer ? 1'b0 : eop_q;
    wcnt_d  = wcnt_q;
    seq_d   = seq_q;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pkt_en && !buf_empty) begin
          dout_d  = {MAGIC, PKT_LEN, seq_q};
          dvld_d  = 1'b1;
          sop_d   = 1'b1;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          state_d = ST_PAY;
          wcnt_d  = '0;
          if (!buf_empty) begin
            rd_en  = 1'b1;
            dout_d = mem_q[rd_ptr_q];
            dvld_d = 1'b1;
            eop_d  = (LAST_IDX == 16'd0);
            wcnt_d = 16'd1;
          end
        end
      end
      ST_PAY: begin
        if (xfer && eop_q) begin
          seq_d = seq_q + 32'd1;
          // Next header goes out straight after the eop beat, no idle cycle.
          if (pkt_en && !buf_empty) begin
            dout_d  = {MAGIC, PKT_LEN, seq_d};
            dvld_d  = 1'b1;
            sop_d   = 1'b1;
            state_d = ST_HDR;
          end else begin
            state_d = ST_IDLE;
          end
        end else if ((!dvld_q || xfer) && (wcnt_q != PKT_LEN) && !buf_empty) begin
          rd_en  = 1'b1;
          dout_d = mem_q[rd_ptr_q];
          dvld_d = 1'b1;
          eop_d  = (wcnt_q == LAST_IDX);
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
      dout_q   <= '0;
      dvld_q   <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      wcnt_q   <= '0;
      seq_q    <= '0;
      ovf_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + (FIFO_AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (FIFO_AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (drop && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
      state_q <= state_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      wcnt_q  <= wcnt_d;
      seq_q   <= seq_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dvld_q;
  assign dout_sop   = sop_q;
  assign dout_eop   = eop_q;
  assign seq_num    = seq_q;
  assign ovf_cnt    = ovf_q;

endmodule
